// File: rtl/cmp_pkg.sv
// Shared constants for the comparator arbiter slice.
// Function codes and requester port indices.
package cmp_pkg;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    localparam logic CMP_PORT_BR  = 1'b0;
    localparam logic CMP_PORT_ALU = 1'b1;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response handshake bundle for one comparator client.
// master = requester side, slave = arbiter side.
interface cmp_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_fn;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_result;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_a, req_b, req_fn, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_fn, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );
endinterface

// File: rtl/cmp.sv
// Single registered 32-bit compare stage.
// Result appears one edge after the operands are presented.
module cmp
    import cmp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  fn,
    output logic        result
);

    logic eq;
    logic slt;
    logic ult;
    logic nxt;

    // decode function code into the compare outcome
    always_comb begin
        eq  = (a == b);
        slt = ($signed(a) < $signed(b));
        ult = (a < b);
        nxt = 1'b0;
        unique case (fn)
            CMP_EQ:  nxt = eq;
            CMP_NE:  nxt = !eq;
            CMP_LT:  nxt = slt;
            CMP_GE:  nxt = !slt;
            CMP_LTU: nxt = ult;
            CMP_GEU: nxt = !ult;
            default: nxt = eq ^ fn[0];
        endcase
    end

    // register the compare outcome
    always_ff @(posedge clk) begin
        if (reset) result <= 1'b0;
        else       result <= nxt;
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin share of one registered comparator between the
// branch port (0) and the ALU slt port (1), with response slots.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    cmp_arbiter_if.slave p0,
    cmp_arbiter_if.slave p1
);

    logic [1:0]       req_v;
    logic [1:0]       resp_rdy;
    logic [1:0]       busy;
    logic [1:0]       drain;
    logic [1:0]       elig;
    logic [1:0]       gnt;
    logic [1:0]       slot_v;
    logic [1:0]       slot_res;
    logic [TAG_W-1:0] slot_tag [2];

    logic             rr_ptr;
    logic             fl_v;
    logic             fl_port;
    logic [TAG_W-1:0] fl_tag;

    logic             sel;
    logic [31:0]      cmp_a;
    logic [31:0]      cmp_b;
    logic [2:0]       cmp_fn;
    logic [TAG_W-1:0] sel_tag;
    logic             cmp_res;

    assign req_v    = {p1.req_valid, p0.req_valid};
    assign resp_rdy = {p1.resp_ready, p0.resp_ready};

    assign busy  = fl_v ? (fl_port ? 2'b10 : 2'b01) : 2'b00;
    assign drain = slot_v & resp_rdy;
    assign elig  = req_v & ~busy & (~slot_v | drain)
                 & {2{~flush & ~reset}};

    // pick one eligible port, rr_ptr breaks ties
    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (elig == 2'b11): gnt = rr_ptr ? 2'b10 : 2'b01;
            default:         gnt = elig;
        endcase
    end

    assign sel     = gnt[1];
    assign cmp_a   = sel ? p1.req_a   : p0.req_a;
    assign cmp_b   = sel ? p1.req_b   : p0.req_b;
    assign cmp_fn  = sel ? p1.req_fn  : p0.req_fn;
    assign sel_tag = sel ? p1.req_tag : p0.req_tag;

    cmp u_cmp (
        .clk    (clk),
        .reset  (reset),
        .a      (cmp_a),
        .b      (cmp_b),
        .fn     (cmp_fn),
        .result (cmp_res)
    );

    // track the op inside cmp and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            fl_v    <= 1'b0;
            fl_port <= CMP_PORT_BR;
            fl_tag  <= '0;
            rr_ptr  <= CMP_PORT_BR;
        end else begin
            fl_v <= |gnt;
            if (|gnt) begin
                fl_port <= gnt[1] ? CMP_PORT_ALU : CMP_PORT_BR;
                fl_tag  <= sel_tag;
                rr_ptr  <= gnt[0] ? CMP_PORT_ALU : CMP_PORT_BR;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        logic             v;
        logic             r;
        logic [TAG_W-1:0] t;

        // one-entry response buffer: fill wins over drain
        always_ff @(posedge clk) begin
            if (reset) begin
                v <= 1'b0;
                r <= 1'b0;
                t <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (busy[i]) begin
                v <= 1'b1;
                r <= cmp_res;
                t <= fl_tag;
            end else if (drain[i]) begin
                v <= 1'b0;
            end
        end

        assign slot_v[i]   = v;
        assign slot_res[i] = r;
        assign slot_tag[i] = t;
    end

    assign p0.req_ready   = gnt[0];
    assign p1.req_ready   = gnt[1];
    assign p0.resp_valid  = slot_v[0];
    assign p1.resp_valid  = slot_v[1];
    assign p0.resp_result = slot_res[0];
    assign p1.resp_result = slot_res[1];
    assign p0.resp_tag    = slot_tag[0];
    assign p1.resp_tag    = slot_tag[1];

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares the single registered comparator unit `cmp` between two requesters: port 0 (branch resolution) and port 1 (ALU set-less-than). Each port has a valid/ready request handshake and a valid/ready response handshake with a one-entry response buffer. Arbitration is round-robin. A flush input kills all in-flight and buffered work on a branch redirect. The block sits in the execute stage between issue and the branch/ALU writeback paths.

## Interface
- `TAG_W`, default 4: width of the opaque request tag returned with each result.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discards all in-flight and buffered results; blocks grants this cycle.
- `p0_req_valid` / `p1_req_valid` in 1: request present.
- `p0_req_ready` / `p1_req_ready` out 1: request accepted this cycle when high together with valid.
- `pN_req_a`, `pN_req_b` in 32: operands.
- `pN_req_fn` in 3: function code; bit0 = negate, bit1 = unsigned, bit2 = less-than.
- `pN_req_tag` in TAG_W: returned unchanged with the result.
- `pN_resp_valid` out 1: result buffered and presented.
- `pN_resp_ready` in 1: consumer takes the result.
- `pN_resp_result` out 1: comparison result.
- `pN_resp_tag` out TAG_W: tag of the presented result.

## Operation
- Port N is eligible when all of these hold:
  - `pN_req_valid` is high.
  - `flush` is low.
  - There is no in-flight op for port N.
  - The port's response slot is empty, or is draining this cycle (`pN_resp_valid && pN_resp_ready`).
- Grant rules:
  - One eligible port: it is granted.
  - Both eligible: the port selected by `rr_ptr` is granted.
  - Neither eligible: no grant, `rr_ptr` holds.
- After a grant, `rr_ptr` flips to point at the non-granted port.
- `pN_req_ready` equals the grant for port N. It is combinational from the current valids, state and `flush`.
- On a grant, the chosen operands and fn drive the `cmp` inputs.
- On a grant, the in-flight register captures {valid=1, port, tag}.
- With no grant, `cmp` inputs are don't-care and in-flight valid is cleared.
- Response capture: when in-flight valid is high, the `cmp.result` value is written into the owning port's response slot on the next edge, together with its tag.
- The response slot clears when drained and not being refilled on the same edge.
- Refill on the same edge as drain is legal; the slot stays valid and holds the new data.
- Flush clears, on the same edge:
  - in-flight valid;
  - both response slots.
  - A response presented in the flush cycle is still considered taken if ready is high.
- `rr_ptr` is unchanged by flush.
- Function codes: EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111. Codes 010 and 011 behave as EQ and NE. Unsigned/signed compare uses full 32-bit operands.

## Timing
- Reset values:
  - `pN_resp_valid`=0; `pN_resp_result`=0; `pN_resp_tag`=0.
  - In-flight valid=0; `rr_ptr`=port 0.
  - `pN_req_ready` is low while `reset` is high.
- Latency: request accepted at edge E → `pN_resp_valid` high in the cycle after edge E+1 (2 cycles).
- Throughput:
  - 1 grant per cycle aggregate.
  - Max 1 grant per port every 2 cycles, because the in-flight op blocks its own port for one cycle.
  - Sustained alternation p0, p1, p0, … achieves 100% comparator use.
- Back-pressure: if `pN_resp_ready` stays low, the slot holds result and tag stable and no further grants go to port N. The other port is unaffected.
- Reset mid-operation: in-flight and buffered results are lost; no response is ever presented for them.

## Structure
- Shared package `cmp_pkg`:
  - Function-code constants `CMP_EQ`, `CMP_NE`, `CMP_LT`, `CMP_GE`, `CMP_LTU`, `CMP_GEU`.
  - Port-index constants `CMP_PORT_BR=0`, `CMP_PORT_ALU=1`.
- Sub-module: one instance of the existing `cmp` unit. It provides the single registered compare stage.
- Per-port response slot logic is identical for both ports and may be a generate loop. No separate module.

## Test plan
- Single op: p0 requests a=5, b=5, fn=EQ, tag=3 with resp_ready=1 → req_ready=1 that cycle; two cycles later p0 resp_valid=1, result=1, tag=3; p1 silent.
- Signed vs unsigned: p1 requests a=0xFFFFFFFF, b=1 with LT, then LTU → results 1, then 0. GE and GEU on the same operands → 0, then 1.
- Contention: both ports request continuously from reset → grants alternate p0, p1, p0, p1; each port gets a response every 2 cycles; tags are returned in order.
- Back-pressure: p0 resp_ready=0 with result pending → p0 req_ready stays 0 and the slot stays stable for 5 cycles; p1 keeps being granted every 2 cycles. Releasing ready drains the slot and permits a p0 grant in the same cycle.
- Flush: grant p1 at cycle N, assert flush at N+1 → no p1 resp_valid ever appears for that op; no grant in the flush cycle; next request is handled normally.
- Reset mid-op: assert reset with one op in-flight and one buffered → all resp_valid=0 next cycle; rr_ptr=0, so a simultaneous request from both ports grants p0 first.
